// File: rtl/seg7_pkg.sv
// Shared types, segment constants and helpers for the multiplexed 7-segment display driver.
// Segment vectors are ordered {a,b,c,d,e,f,g}; 0 = segment lit.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7_decode = 7'b0000001;
      4'd1:    seg7_decode = 7'b1001111;
      4'd2:    seg7_decode = 7'b0010010;
      4'd3:    seg7_decode = 7'b0000110;
      4'd4:    seg7_decode = 7'b1001100;
      4'd5:    seg7_decode = 7'b0100100;
      4'd6:    seg7_decode = 7'b0100000;
      4'd7:    seg7_decode = 7'b0001111;
      4'd8:    seg7_decode = 7'b0000000;
      4'd9:    seg7_decode = 7'b0000100;
      default: seg7_decode = SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed for a w-bit unsigned value: floor(w*log10(2)) + 1.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble converter: IDLE -> LOAD -> SHIFT x DATA_W -> DONE.
// Holds enough BCD digits for the full DATA_W range; exports the low NDIG digits.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NDIG   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bin_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] word,
  output logic [4*NDIG-1:0] bcd
);

  localparam int FULL_DIG = (bcd_digits(DATA_W) > NDIG) ? bcd_digits(DATA_W) : NDIG;
  localparam int CNT_W    = $clog2(DATA_W + 1);

  conv_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [DATA_W-1:0]     sh_q, sh_d;
  logic [4*FULL_DIG-1:0] bcd_q, bcd_d, adj;
  logic                  busy_q, busy_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    adj     = bcd_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        word_d  = bin_in;
        sh_d    = bin_in;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < FULL_DIG; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  // NOTE: reset is synchronous and active-high, so it is tested inside the clocked block;
  // state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = (state_q == DONE);
  assign word = word_q;
  assign bcd  = bcd_q[4*NDIG-1:0];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment driver: source select, BCD conversion, digit scan,
// leading-zero blanking and overflow dash. All outputs are registered.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 32,
  parameter int NSRC        = 5,
  parameter int SEL_W       = 3,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                   clk_pre,
  input  logic                   reset,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       src_sel,
  input  logic                   blank_lz,
  output logic [DIGITS-1:0]      an_n,
  output logic [6:0]             seg_n,
  output logic                   overflow,
  output logic                   busy
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DATA_W:0] OVF_LIMIT = (DATA_W + 1)'(10 ** DIGITS);

  logic [DATA_W-1:0]   sel_word, conv_word;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_busy, conv_done;

  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic                lz_blank;

  // Out-of-range selects fall back to word 0.
  always_comb begin
    sel_word = src_data[0 +: DATA_W];
    for (int i = 1; i < NSRC; i++) begin
      if (src_sel == SEL_W'(i)) sel_word = src_data[i*DATA_W +: DATA_W];
    end
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .NDIG   (DIGITS)
  ) u_conv (
    .clk    (clk_pre),
    .reset  (reset),
    .bin_in (sel_word),
    .busy   (conv_busy),
    .done   (conv_done),
    .word   (conv_word),
    .bcd    (conv_bcd)
  );

  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_done) begin
      disp_d = conv_bcd;
      ovf_d  = ({1'b0, conv_word} >= OVF_LIMIT);
    end

    // Blank only when this digit and everything above it is zero; digit 0 always shows.
    lz_blank = blank_lz && (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) lz_blank = 1'b0;
    end

    an_n_d = ~(DIGITS'(1) << idx_q);
    if (ovf_q)         seg_n_d = SEG_DASH;
    else if (lz_blank) seg_n_d = SEG_BLANK;
    else               seg_n_d = seg7_decode(disp_q[4*idx_q +: 4]);
  end

  always_ff @(posedge clk_pre) begin
    if (reset) begin
      rcnt_q  <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      an_n_q  <= '1;
      seg_n_q <= SEG_BLANK;
    end else begin
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
    end
  end

  assign an_n     = an_n_q;
  assign seg_n    = seg_n_q;
  assign overflow = ovf_q;
  assign busy     = conv_busy;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: stimulus pushes the hand-computed per-slot segment
// pattern of each conversion; a monitor pops one entry per conversion end and checks a full scan.
module tb_seg7_scan_display;

  localparam int DIGITS = 4;
  localparam int DATA_W = 32;
  localparam int NSRC   = 5;
  localparam int SEL_W  = 3;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b1111110;

  typedef struct packed {
    logic            ovf;
    logic [3:0][6:0] seg;
  } exp_t;

  logic                   clk_pre = 1'b0;
  logic                   reset;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]       src_sel;
  logic                   blank_lz;
  logic [DIGITS-1:0]      an_n;
  logic [6:0]             seg_n;
  logic                   overflow;
  logic                   busy;

  logic [DATA_W-1:0] w [NSRC];
  logic              busy_d1 = 1'b0;
  logic              mon_en = 1'b0;
  logic              mon_busy = 1'b0;
  exp_t              sb_q [$];
  int                checks = 0;
  int                errors = 0;

  assign src_data = {w[4], w[3], w[2], w[1], w[0]};

  always #5 clk_pre = ~clk_pre;
  always @(posedge clk_pre) busy_d1 <= busy;

  seg7_scan_display #(
    .DIGITS      (DIGITS),
    .DATA_W      (DATA_W),
    .NSRC        (NSRC),
    .SEL_W       (SEL_W),
    .REFRESH_DIV (4)
  ) dut (
    .clk_pre  (clk_pre),
    .reset    (reset),
    .src_data (src_data),
    .src_sel  (src_sel),
    .blank_lz (blank_lz),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic ovf, input logic [6:0] s0, s1, s2, s3);
    exp_t e;
    e.ovf    = ovf;
    e.seg[0] = s0;
    e.seg[1] = s1;
    e.seg[2] = s2;
    e.seg[3] = s3;
    return e;
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Returns on the negedge inside the DONE cycle of a conversion.
  task automatic wait_fall();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_pre);
      if (!reset && busy_d1 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no conversion end within 100 cycles at %0t", $time);
    end
  endtask

  // Select/word are set right after a DONE so the next LOAD samples them; blank_lz is
  // changed only once the monitor has finished scanning the previous conversion.
  task automatic issue(input logic [2:0] sel, input logic [31:0] word4, input logic bl,
                       input exp_t e, input bit chg, input logic [2:0] sel2);
    wait_fall();
    src_sel = sel;
    w[4]    = word4;
    sb_q.push_back(e);
    if (chg) begin
      repeat (13) @(negedge clk_pre);
      src_sel = sel2;
      repeat (7) @(negedge clk_pre);
    end else begin
      repeat (20) @(negedge clk_pre);
    end
    blank_lz = bl;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] seen;
    int         idx;
    forever begin
      @(negedge clk_pre);
      if (mon_en && !reset && busy_d1 && !busy && sb_q.size() > 0) begin
        mon_busy = 1'b1;
        e = sb_q.pop_front();
        @(negedge clk_pre);
        check("overflow", 32'(overflow), 32'(e.ovf));
        @(negedge clk_pre);
        seen = '0;
        for (int k = 0; k < 16; k++) begin
          idx = slot_of(an_n);
          if (idx < 0) begin
            check("an_n_onehot", 32'(an_n), 32'hE);
          end else if (!seen[idx]) begin
            seen[idx] = 1'b1;
            check($sformatf("seg_slot%0d", idx), 32'(seg_n), 32'(e.seg[idx]));
          end
          @(negedge clk_pre);
        end
        check("slots_seen", 32'(seen), 32'hF);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] seq [5];
    logic [3:0] prev_an;
    bit         ok;

    reset    = 1'b1;
    blank_lz = 1'b0;
    src_sel  = 3'd1;
    w[0] = 32'd1234;
    w[1] = 32'd80;
    w[2] = 32'd507;
    w[3] = 32'd0;
    w[4] = 32'd10000;
    mon_en = 1'b1;
    sb_q.push_back(mk(1'b0, S0, S8, S0, S0));

    repeat (3) @(posedge clk_pre);
    @(negedge clk_pre);
    check("reset_an_n", 32'(an_n), 32'hF);
    check("reset_seg_n", 32'(seg_n), 32'(BL));
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_pre);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("busy_after_reset", 32'(ok), 32'd1);

    issue(3'd1, 32'd10000,     1'b1, mk(1'b0, S0, S8, BL, BL), 1'b0, 3'd0);
    issue(3'd4, 32'd10000,     1'b0, mk(1'b1, DS, DS, DS, DS), 1'b0, 3'd0);
    issue(3'd4, 32'd9999,      1'b0, mk(1'b0, S9, S9, S9, S9), 1'b0, 3'd0);
    issue(3'd3, 32'd9999,      1'b1, mk(1'b0, S0, BL, BL, BL), 1'b0, 3'd0);
    issue(3'd1, 32'd9999,      1'b0, mk(1'b0, S0, S8, S0, S0), 1'b1, 3'd2);
    issue(3'd2, 32'd9999,      1'b1, mk(1'b0, S7, S0, S5, BL), 1'b0, 3'd0);
    issue(3'd7, 32'd9999,      1'b0, mk(1'b0, S4, S3, S2, S1), 1'b0, 3'd0);
    issue(3'd4, 32'd1005,      1'b1, mk(1'b0, S5, S0, S0, S1), 1'b0, 3'd0);
    issue(3'd4, 32'hFFFF_FFFF, 1'b0, mk(1'b1, DS, DS, DS, DS), 1'b0, 3'd0);
    issue(3'd4, 32'd9,         1'b1, mk(1'b0, S9, BL, BL, BL), 1'b0, 3'd0);

    for (int i = 0; i < 200 && (sb_q.size() > 0 || mon_busy); i++) @(negedge clk_pre);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    mon_en   = 1'b0;
    blank_lz = 1'b0;

    // Scan order and dwell: each enable held exactly 4 cycles.
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;
    ok = 1'b0;
    @(negedge clk_pre);
    prev_an = an_n;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_pre);
      if (an_n == 4'b1110 && prev_an != 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev_an = an_n;
    end
    check("scan_sync", 32'(ok), 32'd1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("scan_slot%0d_cycle%0d", k, j), 32'(an_n), 32'(seq[k]));
        @(negedge clk_pre);
      end
    end

    // Reset during SHIFT aborts the conversion and clears the display.
    wait_fall();
    repeat (13) @(negedge clk_pre);
    reset = 1'b1;
    @(negedge clk_pre);
    check("midreset_an_n", 32'(an_n), 32'hF);
    check("midreset_seg_n", 32'(seg_n), 32'(BL));
    check("midreset_overflow", 32'(overflow), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk_pre);
    check("postreset_an_n", 32'(an_n), 32'hE);
    check("postreset_seg_digit0", 32'(seg_n), 32'(S0));
    check("postreset_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk_pre);
    check("postreset_an_n_slot1", 32'(an_n), 32'hD);
    check("postreset_seg_digit1", 32'(seg_n), 32'(S0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
